// File: rtl/pipeline_ctrl.sv
// Pipeline latch controller: turns hazard stall/flush requests and memory handshake
// status into per-latch enable/flush strobes, with halt latching and perf counters.
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        exmem_dren,
    input  logic        exmem_dwen,
    input  logic        lw_nop,
    input  logic        jmp_flush,
    input  logic        brch_flush,
    input  logic        wb_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        halt_out,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   pend;
    logic   freeze;
    logic   redir;
    logic   flush_hit;

    assign freeze = (exmem_dren | exmem_dwen) & ~dhit;
    assign redir  = jmp_flush | brch_flush | pend;

    // State, deferred-flush flag and saturating counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= RUN;
            pend         <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state <= state_nx;
            if (state != HALT) begin
                if (freeze && (jmp_flush || brch_flush)) begin
                    pend <= 1'b1;
                end else if (flush_hit) begin
                    pend <= 1'b0;
                end
                if (!pc_en && stall_cycles != CNT_MAX) begin
                    stall_cycles <= stall_cycles + CNT_W'(1);
                end
                if (flush_hit && flush_count != CNT_MAX) begin
                    flush_count <= flush_count + CNT_W'(1);
                end
            end
        end
    end

    // Next state and prioritised latch strobes
    always_comb begin
        state_nx   = state;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        halt_out   = 1'b0;
        flush_hit  = 1'b0;

        if (state == HALT) begin
            halt_out = 1'b1;
        end else if (wb_halt) begin
            halt_out = 1'b1;
            state_nx = HALT;
        end else if (freeze) begin
            state_nx = DWAIT;
        end else begin
            state_nx = RUN;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            idex_en  = 1'b1;
            ifid_en  = 1'b1;
            if (redir) begin
                // A flush overrides the enable, so the fetch redirect proceeds even without ihit
                pc_en      = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                flush_hit  = 1'b1;
            end else if (lw_nop) begin
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (!ihit) begin
                ifid_flush = 1'b1;
            end else begin
                pc_en = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes model predictions, a negedge
// monitor pops and compares them against the live outputs.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, exmem_dren, exmem_dwen, lw_nop, jmp_flush, brch_flush, wb_halt;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halt_out;
    logic [15:0] stall_cycles, flush_count;

    typedef struct packed {
        logic [7:0]  outs;
        logic [15:0] stall;
        logic [15:0] flush;
        logic        final_chk;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: halted flag, deferred flush flag, plain integer counters
    bit   m_halted;
    bit   m_pend;
    int   m_stall;
    int   m_flush;

    pipeline_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .exmem_dren(exmem_dren), .exmem_dwen(exmem_dwen), .lw_nop(lw_nop),
        .jmp_flush(jmp_flush), .brch_flush(brch_flush), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .halt_out(halt_out), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 CLK = ~CLK;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halt_out}
    task automatic cycle(input bit r, input bit ih, input bit dh, input bit dr, input bit dw,
                         input bit lw, input bit jf, input bit bf, input bit wh);
        exp_t e;
        bit   frz, rd, took_redir;
        @(posedge CLK);
        #1;
        RST = r; ihit = ih; dhit = dh; exmem_dren = dr; exmem_dwen = dw;
        lw_nop = lw; jmp_flush = jf; brch_flush = bf; wb_halt = wh;
        cyc++;
        if (r) begin
            m_halted = 0; m_pend = 0; m_stall = 0; m_flush = 0;
        end
        frz = (dr || dw) && !dh;
        rd  = jf || bf || m_pend;
        took_redir = 0;
        if (m_halted || wh)  e.outs = 8'b0000_0001;
        else if (frz)        e.outs = 8'b0000_0000;
        else if (rd) begin   e.outs = 8'b1111_1110; took_redir = 1; end
        else if (lw)         e.outs = 8'b0001_1110;
        else if (!ih)        e.outs = 8'b0111_0110;
        else                 e.outs = 8'b1101_0110;
        e.stall = 16'(m_stall);
        e.flush = 16'(m_flush);
        e.final_chk = 1'b0;
        exp_q.push_back(e);
        if (!r && !m_halted) begin
            if (!e.outs[7] && m_stall < 65535) m_stall++;
            if (took_redir && m_flush < 65535) m_flush++;
            if (frz && (jf || bf)) m_pend = 1;
            else if (took_redir)   m_pend = 0;
            if (wh) m_halted = 1;
        end
    endtask

    task automatic idle(input bit ih);
        cycle(0, ih, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest prediction
    initial begin
        exp_t e;
        logic [7:0] got;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halt_out};
                checks++;
                if (got !== e.outs) begin
                    errors++;
                    $display("FAIL strobes cyc=%0d got=%b exp=%b", cyc, got, e.outs);
                end
                checks++;
                if (stall_cycles !== e.stall) begin
                    errors++;
                    $display("FAIL stall_cycles cyc=%0d got=%h exp=%h", cyc, stall_cycles, e.stall);
                end
                checks++;
                if (flush_count !== e.flush) begin
                    errors++;
                    $display("FAIL flush_count cyc=%0d got=%h exp=%h", cyc, flush_count, e.flush);
                end
            end
        end
    end

    initial begin
        int p_wh, p_rst;
        RST = 1; ihit = 0; dhit = 0; exmem_dren = 0; exmem_dwen = 0;
        lw_nop = 0; jmp_flush = 0; brch_flush = 0; wb_halt = 0;

        // Post-reset: bubbles counted, then free running
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) idle(0);
        repeat (3) idle(1);

        // Load-use stall
        cycle(0, 1, 0, 0, 0, 1, 0, 0, 0);
        idle(1);

        // Deferred branch flush across a 3-cycle load freeze, released alone
        repeat (3) cycle(0, 1, 0, 1, 0, 0, 0, 1, 0);
        cycle(0, 1, 1, 1, 0, 0, 0, 0, 0);
        idle(1);
        idle(1);

        // Pending flush coincides with a live jump on release: one flush only
        repeat (2) cycle(0, 1, 0, 0, 1, 0, 1, 0, 0);
        cycle(0, 1, 1, 0, 1, 0, 1, 0, 0);
        idle(1);

        // Redirect beats lw_nop and missing ihit
        cycle(0, 0, 0, 0, 0, 1, 0, 1, 0);
        idle(1);

        // Halt is sticky and ignores everything until reset
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 1, 1, 1, 0);
        repeat (3) idle(0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Saturation of stall_cycles
        repeat (65540) idle(0);
        idle(1);

        // Reset during a freeze with a pending flush: nothing is replayed
        repeat (2) cycle(0, 1, 0, 1, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 0, 0, 0, 0, 0);
        idle(1);

        // Randomised traffic with occasional halts and resets
        for (int i = 0; i < 3000; i++) begin
            p_wh  = $urandom_range(0, 299);
            p_rst = $urandom_range(0, 199);
            cycle(p_rst == 0,
                  $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 12,
                  p_wh == 0);
        end

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline latch controller: consumes the stall/flush requests raised by the hazard logic (`lw_nop`, `jmp_flush`, `brch_flush`) together with memory handshake status. It converts them into per-latch enable/flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It tracks data-memory freezes, holds flush requests across a freeze, latches halt, and keeps saturating stall/flush performance counters.

## Interface
- No parameters.
- `CLK` in 1: system clock, rising edge.
- `RST` in 1: asynchronous reset, active-high.
- `ihit` in 1: instruction fetch complete this cycle.
- `dhit` in 1: data access complete this cycle.
- `exmem_dren` in 1: EX/MEM holds a load.
- `exmem_dwen` in 1: EX/MEM holds a store.
- `lw_nop` in 1: load-use stall request.
- `jmp_flush` in 1: J/JAL/JR redirect flush request.
- `brch_flush` in 1: taken-branch flush request.
- `wb_halt` in 1: halt instruction at MEM/WB output.
- `pc_en` out 1: PC may update.
- `ifid_en` out 1: IF/ID latch enable.
- `ifid_flush` out 1: IF/ID loads a bubble.
- `idex_en` out 1: ID/EX latch enable.
- `idex_flush` out 1: ID/EX loads a bubble.
- `exmem_en` out 1: EX/MEM latch enable.
- `memwb_en` out 1: MEM/WB latch enable.
- `halt_out` out 1: processor halted.
- `stall_cycles` out 16: count of cycles with `pc_en`=0 outside HALT.
- `flush_count` out 16: count of effective redirect flushes.

## Operation
- Latch semantics: a flush strobe loads zeros and overrides the enable. Whenever a flush is 1, the matching enable is also driven 1.
- Internal state: FSM {RUN, DWAIT, HALT}, `pend` (1 bit), and both counters.
- `freeze` = (`exmem_dren` | `exmem_dwen`) & ~`dhit`.
- `redir` = `jmp_flush` | `brch_flush` | `pend`.
- Output priority is combinational and applies in RUN and DWAIT:
  1. `wb_halt`: all enables 0, all flushes 0, `halt_out`=1.
  2. `freeze`: all enables 0, all flushes 0.
  3. `redir`: `pc_en`=1 regardless of `ihit`; `ifid_flush`=1, `idex_flush`=1; `exmem_en`=`memwb_en`=1.
  4. `lw_nop`: `pc_en`=0, `ifid_en`=0 (hold), `idex_flush`=1; `exmem_en`=`memwb_en`=1.
  5. `~ihit`: `pc_en`=0, `ifid_flush`=1; `idex_en`=`exmem_en`=`memwb_en`=1.
  6. Otherwise all enables 1, all flushes 0.
- HALT: all enables 0, all flushes 0, `halt_out`=1. Sticky until `RST`; every other input is ignored.
- Transitions:
  - Any state other than HALT goes to HALT when `wb_halt`=1.
  - RUN goes to DWAIT when `freeze`.
  - DWAIT goes to RUN when `~freeze`.
- `pend` update:
  - Set on any edge where `freeze` & (`jmp_flush` | `brch_flush`).
  - Cleared on any edge where rule 3 was applied.
  - A set and a clear never coincide, because rule 3 excludes `freeze`.
- `stall_cycles` increments on each edge where the state is not HALT and `pc_en`=0. It saturates at 0xFFFF.
- `flush_count` increments by exactly 1 on each edge where rule 3 applied, including when `pend` and a live request coincide. It saturates at 0xFFFF.

## Timing
- All outputs are combinational from inputs and registered state, so they are valid in the same cycle as the inputs.
- State, `pend` and counters update on the rising edge of `CLK`.
- On `RST`, asynchronously and immediately: state=RUN, `pend`=0, `stall_cycles`=0, `flush_count`=0, `halt_out`=0.
- Outputs with `RST` asserted: `pc_en`=0, `ifid_en`=1, `ifid_flush`=1, `idex_en`=1, `idex_flush`=0, `exmem_en`=1, `memwb_en`=1, `halt_out`=0. These follow from rule 5, since `ihit`=0 while in reset.
- Latency from a freeze release to the first redirect: 0 cycles. The release cycle itself applies rule 3 if `pend`=1.
- `RST` mid-DWAIT with `pend`=1 returns to RUN with `pend`=0. No flush is replayed.
- `lw_nop` together with a redirect: the redirect wins, and `ifid_en`=1 because the flush overrides.
- A multi-cycle `~ihit` with no other request gives one bubble per cycle. `stall_cycles` increments each of those cycles.

## Test plan
- **Post-reset:** `RST` pulse, all inputs 0 → reset output values above, `stall_cycles` increments each cycle. Then `ihit`=1 → all enables 1, counter frozen.
- **Load-use:** `ihit`=1, `lw_nop`=1 for 1 cycle → `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `exmem_en`=1, `stall_cycles` +1, `flush_count` unchanged.
- **Deferred flush:** `exmem_dren`=1, `dhit`=0 for 3 cycles with `brch_flush`=1 → all enables 0 for 3 cycles, state DWAIT, `pend`=1. Then `dhit`=1 with `brch_flush`=0 → same cycle `ifid_flush`=`idex_flush`=1, `pc_en`=1; next edge `pend`=0, `flush_count`=1.
- **Coincident redirect:** `pend`=1 and `jmp_flush`=1 on the release cycle → one flush cycle, `flush_count` +1 only.
- **Halt:** `wb_halt`=1 for 1 cycle → `halt_out`=1 immediately and stays 1 with `wb_halt`=0, all enables 0, counters frozen. `RST` clears to RUN.
- **Saturation/reset mid-op:** hold `ihit`=0 for 65540 cycles → `stall_cycles`=0xFFFF. Then assert `RST` during DWAIT with `pend`=1 → counters 0, `pend`=0, state RUN.
